// File: rtl/pipe_sub16_pkg.sv
// Shared constants and the per-stage pipeline record for pipe_sub16.
package pipe_sub16_pkg;

  localparam int WIDTH = 16;
  localparam int NIB = 4;
  localparam int STAGES = 4;

  localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

  // One pipeline slot. lo_result holds nibbles already resolved;
  // hi_a / hi_nb hold the minuend and inverted subtrahend nibbles still
  // waiting for their carry. sa / sb are the operand signs for overflow.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] lo_result;
    logic [WIDTH-1:0] hi_a;
    logic [WIDTH-1:0] hi_nb;
    logic             sa;
    logic             sb;
  } stage_t;

endpackage

// File: rtl/pipe_sub16_cla_slice4.sv
// 4-bit carry-lookahead adder slice (purely combinational).
module cla_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate lookahead: every carry is a flat sum of products.
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end

endmodule

// File: rtl/pipe_sub16.sv
// Pipelined 16-bit subtractor d = a - b, one nibble resolved per stage.
// Optional macro PIPE_SUB16_SAT_EN clamps d to the signed range on overflow.
// pipe[0] captures the operands (carry-in 1, b inverted); pipe[k+1] holds the
// record after nibble k has been resolved; pipe[STAGES] drives the outputs.
module pipe_sub16
  import pipe_sub16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  stage_t           pipe [STAGES+1];
  stage_t           nxt  [STAGES];
  logic [NIB-1:0]   sum  [STAGES];
  logic             co   [STAGES];
  logic             adv;
  logic [WIDTH-1:0] d_raw;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla_slice4 u_cla (
      .x  (pipe[k].hi_a[NIB*k +: NIB]),
      .y  (pipe[k].hi_nb[NIB*k +: NIB]),
      .ci (pipe[k].carry),
      .s  (sum[k]),
      .co (co[k])
    );
  end

  // Fold each slice result into its record; resolved operand nibbles are dropped.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]                            = pipe[k];
      nxt[k].carry                      = co[k];
      nxt[k].lo_result[NIB*k +: NIB]    = sum[k];
      nxt[k].hi_a[NIB*k +: NIB]         = '0;
      nxt[k].hi_nb[NIB*k +: NIB]        = '0;
    end
  end

  // Whole pipeline shifts together whenever the output slot can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= STAGES; i++) pipe[i] <= '0;
    end else if (adv) begin
      pipe[0] <= '{valid:     in_valid,
                   carry:     1'b1,
                   lo_result: '0,
                   hi_a:      a,
                   hi_nb:     ~b,
                   sa:        a[WIDTH-1],
                   sb:        b[WIDTH-1]};
      for (int k = 0; k < STAGES; k++) pipe[k+1] <= nxt[k];
    end
  end

  assign out_valid = pipe[STAGES].valid;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign d_raw     = pipe[STAGES].lo_result;
  // Gated by valid so a cleared record reads as "no borrow".
  assign bout      = pipe[STAGES].valid & ~pipe[STAGES].carry;
  assign ovf       = (pipe[STAGES].sa ^ pipe[STAGES].sb) & (d_raw[WIDTH-1] ^ pipe[STAGES].sa);

`ifdef PIPE_SUB16_SAT_EN
  assign d = ovf ? (pipe[STAGES].sa ? SAT_NEG : SAT_POS) : d_raw;
`else
  assign d = d_raw;
`endif

endmodule

// File: tb/tb_pipe_sub16.sv
// Scoreboard bench for pipe_sub16.
module tb_pipe_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b, d;
  logic        in_valid, in_ready, out_valid, out_ready, bout, ovf;

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  logic [15:0] pend_d;
  logic        pend_bout, pend_ovf;

  pipe_sub16 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] dd, output logic bb, output logic oo);
    logic [15:0] w;
    w  = x - y;
    bb = (x < y);
    oo = (x[15] != y[15]) && (w[15] != x[15]);
`ifdef PIPE_SUB16_SAT_EN
    dd = oo ? (x[15] ? 16'h8000 : 16'h7FFF) : w;
`else
    dd = w;
`endif
  endfunction

  function automatic logic [15:0] rval();
    case ($urandom % 8)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("d", 32'(d), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bout));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          if (chk_lat) chk("latency", 32'(cyc - e.acc), 32'd4);
        end
      end
      if (in_valid && in_ready)
        q.push_back('{d: pend_d, bout: pend_bout, ovf: pend_ovf, acc: cyc + 1});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge, in_valid still high.
  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] ed, input logic eb, input logic eo);
    int n = 0;
    a = x; b = y; pend_d = ed; pend_bout = eb; pend_ovf = eo; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] ed;
    logic eb, eo;
    model(x, y, ed, eb, eo);
    send(x, y, ed, eb, eo);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    logic [15:0] ed;
    logic        eb, eo;
    int          n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    pend_d = '0; pend_bout = 1'b0; pend_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed single operations with latency checking.
    chk_lat = 1'b1;
    send(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0); drain();
    send(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0); drain();
    send(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0); drain();
`ifdef PIPE_SUB16_SAT_EN
    send(16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1); drain();
    send(16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1); drain();
`else
    send(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1); drain();
    send(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1); drain();
`endif
    send(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0); drain();

    // Back-to-back stream at full rate: every result still 4 cycles after accept.
    send(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    send(16'h0100, 16'h0200, 16'hFF00, 1'b1, 1'b0);
    send(16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    drain();

    // Stall at the first of 4 results for 3 cycles.
    chk_lat = 1'b0;
    send_model(16'h4000, 16'h0001);
    send_model(16'h0003, 16'h0009);
    send_model(16'h8001, 16'h7FFF);
    send_model(16'h7000, 16'h9000);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_result_seen", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    held = d;
    model(16'h5555, 16'h1111, ed, eb, eo);
    a = 16'h5555; b = 16'h1111; pend_d = ed; pend_bout = eb; pend_ovf = eo; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_d_hold", 32'(d), 32'(held));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_model(16'h5555, 16'h1111);
    drain();

    // Reset with two operations in flight.
    send_model(16'h2222, 16'h1111);
    send_model(16'h0001, 16'h0002);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flush_in_ready", 32'(in_ready), 32'd1);
    chk_lat = 1'b1;
    send(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0);
    drain();
    repeat (10) @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    chk_lat = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] x, y;
      x = rval();
      y = rval();
      model(x, y, ed, eb, eo);
      a = x; b = y; pend_d = ed; pend_bout = eb; pend_ovf = eo;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
